// File: rtl/nco_pkg.sv
// Shared widths, quadrant encodings and quarter-wave table generator
// for the chirp sinusoid generator.
package nco_pkg;

    localparam int N_DEF = 32;
    localparam int P_DEF = 12;
    localparam int M_DEF = 12;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    // Half-sample offset keeps the mirrored quadrants exactly symmetric.
    function automatic int rom_entry(input int j, input int p, input int m);
        real amp;
        real ang;
        amp = real'((1 << (m - 1)) - 1);
        ang = 2.0 * 3.14159265358979323846 * (real'(j) + 0.5)
              / real'(1 << p);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/chirp_nco_rom.sv
// Registered quarter-wave sine table; contents fixed at elaboration,
// no reset since the top level mutes its output.
module chirp_nco_rom
    import nco_pkg::*;
#(
    parameter int P = P_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic [P-3:0] addr,
    output logic [M-2:0] data
);

    localparam int DEPTH = 2 ** (P - 2);

    logic [M-2:0] tbl [DEPTH];

    for (genvar j = 0; j < DEPTH; j++) begin : g_tbl
        localparam int V = rom_entry(j, P, M);
        assign tbl[j] = (M - 1)'(V);
    end

    always_ff @(posedge clk) begin
        data <= tbl[addr];
    end

endmodule

// File: rtl/chirp_nco.sv
// Phase accumulator NCO: quadrant fold, quarter-wave lookup, sign
// restore; nco_reset clears phase and mutes the output.
module chirp_nco
    import nco_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int P = P_DEF,
    parameter int M = M_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nco_reset,
    input  logic [N-1:0]        nco_ctrl,
    output logic signed [M-1:0] sine,
    output logic                sine_valid,
    output logic [N-1:0]        phase
);

    logic [N-1:0]        acc;
    logic [P-1:0]        p;
    quadrant_e           q;
    logic [P-3:0]        i;

    logic [P-3:0]        addr1;
    logic                neg1;
    logic                mute1;

    logic [M-2:0]        rom2;
    logic                neg2;
    logic                mute2;
    logic signed [M-1:0] mag;

    assign p     = acc[N-1:N-P];
    assign q     = quadrant_e'(p[P-1:P-2]);
    assign i     = p[P-3:0];
    assign mag   = {1'b0, rom2};
    assign phase = acc;

    chirp_nco_rom #(
        .P (P),
        .M (M)
    ) u_rom (
        .clk  (clk),
        .addr (addr1),
        .data (rom2)
    );

    // Mute flags reset high so the unreset ROM output never escapes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc        <= '0;
            addr1      <= '0;
            neg1       <= 1'b0;
            mute1      <= 1'b1;
            neg2       <= 1'b0;
            mute2      <= 1'b1;
            sine       <= '0;
            sine_valid <= 1'b0;
        end else begin
            acc   <= nco_reset ? '0 : acc + nco_ctrl;
            mute1 <= nco_reset;
            unique case (q)
                Q0: begin addr1 <= i;  neg1 <= 1'b0; end
                Q1: begin addr1 <= ~i; neg1 <= 1'b0; end
                Q2: begin addr1 <= i;  neg1 <= 1'b1; end
                Q3: begin addr1 <= ~i; neg1 <= 1'b1; end
                default: begin addr1 <= i; neg1 <= 1'b0; end
            endcase
            neg2  <= neg1;
            mute2 <= mute1;
            if (mute2) begin
                sine       <= '0;
                sine_valid <= 1'b0;
            end else begin
                sine       <= neg2 ? -mag : mag;
                sine_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chirp_nco.sv
// Scoreboard bench for chirp_nco against a real-valued sine model.
module tb_chirp_nco;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               nco_reset = 1'b0;
    logic [31:0]        nco_ctrl = 32'h4000_0000;
    logic signed [11:0] sine;
    logic               sine_valid;
    logic [31:0]        phase;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic valid;
        int   val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] macc = '0;

    chirp_nco dut (
        .clk        (clk),
        .rst        (rst),
        .nco_reset  (nco_reset),
        .nco_ctrl   (nco_ctrl),
        .sine       (sine),
        .sine_valid (sine_valid),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    function automatic int ref_sine(input logic [31:0] a);
        int  idx;
        real s;
        int  m;
        idx = int'(a[31:20]);
        s = $sin(2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / 4096.0);
        m = $rtoi(2047.0 * (s < 0.0 ? -s : s) + 0.5);
        return (s < 0.0) ? -m : m;
    endfunction

    // Reference model: what each edge commits, and when it shows up.
    always @(posedge clk) begin
        exp_t e;
        if (!rst) begin
            sb.delete();
            e.valid = 1'b0;
            e.val   = 0;
            repeat (3) sb.push_back(e);
            macc = '0;
        end else begin
            e.valid = !nco_reset;
            e.val   = nco_reset ? 0 : ref_sine(macc);
            sb.push_back(e);
            macc = nco_reset ? 32'h0 : macc + nco_ctrl;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (sine_valid !== e.valid || int'(sine) != e.val) begin
                bad++;
                $display("FAIL sample t=%0t got sine=%0d valid=%0b want sine=%0d valid=%0b",
                         $time, sine, sine_valid, e.val, e.valid);
            end
            total++;
            if (phase !== macc) begin
                bad++;
                $display("FAIL phase t=%0t got %h want %h", $time, phase, macc);
            end
        end
    end

    task automatic drive(input logic r, input logic nr,
                         input logic [31:0] c, input int cyc);
        rst       = r;
        nco_reset = nr;
        nco_ctrl  = c;
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        logic [31:0] c;
        logic        nr;
        logic        r;
        drive(1'b0, 1'b0, 32'h4000_0000, 4);
        drive(1'b1, 1'b0, 32'h4000_0000, 16);
        drive(1'b1, 1'b1, 32'h0000_0000, 1);
        drive(1'b1, 1'b0, 32'h0000_0000, 8);
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1);
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 10);
        drive(1'b1, 1'b0, 32'h1234_5678, 10);
        drive(1'b1, 1'b1, 32'h1234_5678, 3);
        drive(1'b1, 1'b0, 32'h1234_5678, 10);
        drive(1'b0, 1'b0, 32'h1234_5678, 1);
        drive(1'b1, 1'b0, 32'h1234_5678, 10);
        c = $urandom;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) c = $urandom;
            nr = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 63) != 0);
            drive(r, nr, c, 1);
        end
        drive(1'b1, 1'b0, 32'h0800_0000, 8);
        if (total < 12) begin
            bad++;
            $display("FAIL count got %0d want >=12", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
